dmem_responder: RTL

Data-memory responder on the memory side of the pipeline's data-memory request interface. It accepts read/write requests from the data-memory stage (address, write data, read/write strobes) and services them from an internal word-addressed array after a configurable wait-state count. It returns read data and a ready handshake that the pipeline uses as a stall signal. Store byte-lane merging is big-endian, matching the lane convention used by load alignment in the data-memory stage.

---
 rtl/dmem_responder.sv | 87 ++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory responder with big-endian store lane merging
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead_2DM,
  input  logic        MemWrite_2DM,
  input  logic [31:0] data_address_2DM,
  input  logic [31:0] data_write_2DM,
  input  logic [1:0]  store_size,
  output logic [31:0] data_read_fDM,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        addr_err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [31:0]           a_q, d_q;
  logic [1:0]            sz_q;
  logic                  wr_q, both_q;
  logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  oor, mis, fire, we;
  logic [4:0]            sh;
  logic [31:0]           mask, cur, merged;
  // decode the latched request and build the read-modify-write word
  always_comb begin
    idx    = a_q[DEPTH_LOG2+1:2];
    oor    = |a_q[31:DEPTH_LOG2+2];
    mis    = sz_q == 2'd0 ? 1'b0 : sz_q == 2'd1 ? a_q[0] : |a_q[1:0];
    fire   = state == WAIT && cnt == 4'd0;
    we     = fire && wr_q && !oor && !mis;
    sh     = sz_q == 2'd0 ? {~a_q[1:0], 3'b000} : sz_q == 2'd1 ? {~a_q[1], 4'b0000} : 5'd0;
    mask   = (sz_q == 2'd0 ? 32'h0000_00FF : sz_q == 2'd1 ? 32'h0000_FFFF : 32'hFFFF_FFFF) << sh;
    cur    = mem[idx];
    merged = (cur & ~mask) | ((d_q << sh) & mask);
  end
  // capture the request while idle; held stable afterwards by ignoring inputs
  always_ff @(posedge CLK) begin
    if (state == IDLE) begin
      a_q    <= data_address_2DM;
      d_q    <= data_write_2DM;
      sz_q   <= store_size;
      wr_q   <= MemWrite_2DM;
      both_q <= MemRead_2DM && MemWrite_2DM;
    end
  end
  // array update, gated off by the FSM being forced idle under reset
  always_ff @(posedge CLK) begin
    if (we) mem[idx] <= merged;
  end
  // request sequencing and registered handshake outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      data_read_fDM <= 32'd0;
      mem_ready     <= 1'b0;
      mem_busy      <= 1'b0;
      addr_err      <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      addr_err  <= 1'b0;
      if (state == IDLE) begin
        if (MemRead_2DM || MemWrite_2DM) begin
          cnt      <= LAT_M1;
          mem_busy <= 1'b1;
          state    <= WAIT;
        end
      end else if (state == WAIT) begin
        if (fire) begin
          state     <= DONE;
          mem_busy  <= 1'b0;
          mem_ready <= 1'b1;
          addr_err  <= both_q || oor || (wr_q && mis);
          if (!wr_q) data_read_fDM <= oor ? 32'd0 : cur;
        end else cnt <= cnt - 4'd1;
      end else state <= IDLE;
    end
  end
endmodule
